// File: rtl/serial_link_hex_if.sv
// Pushbutton, serial line and hex display signals of one serial_link_hex engine.
interface serial_link_hex_if #(
  parameter int DATA_W = 16
);
  logic                  load_btn;
  logic                  start_btn;
  logic [DATA_W-1:0]     pb_in;
  logic                  serial_in;
  logic                  serial_out;
  logic                  busy;
  logic                  done;
  logic                  rx_valid;
  logic                  frame_err;
  logic [2*DATA_W-1:0]   hex_out;  // 8 segment bits per 4-bit digit

  modport master (
    output load_btn, start_btn, pb_in, serial_in,
    input  serial_out, busy, done, rx_valid, frame_err, hex_out
  );

  modport slave (
    input  load_btn, start_btn, pb_in, serial_in,
    output serial_out, busy, done, rx_valid, frame_err, hex_out
  );
endinterface

// File: rtl/serial_link_hex.sv
// Framed serial TX/RX engine with hex display; SERIAL_PARITY_EN adds an even-parity bit.
// Buttons act two edges after press; no backpressure, button edges while busy are dropped.
module serial_link_hex #(
  parameter int DATA_W  = 16,
  parameter int BIT_CYC = 1
) (
  input logic              clk,
  input logic              reset,
  serial_link_hex_if.slave bus
);
  localparam int NDIG = DATA_W / 4;
  localparam int CW   = $clog2(BIT_CYC + 1);
  localparam int IW   = $clog2(DATA_W);
`ifdef SERIAL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam logic [CW-1:0] LAST    = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF    = CW'(BIT_CYC / 2);
  localparam logic [IW-1:0] IDX_TOP = IW'(DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  // Two synchroniser flops plus one history flop per button.
  logic [2:0] ld_sync, st_sync;
  logic       load_edge, start_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_sync <= '0;
      st_sync <= '0;
    end else begin
      ld_sync <= {ld_sync[1:0], bus.load_btn};
      st_sync <= {st_sync[1:0], bus.start_btn};
    end
  end

  assign load_edge  = ld_sync[1] & ~ld_sync[2];
  assign start_edge = st_sync[1] & ~st_sync[2];

  logic [2:0]        tx_state;
  logic [CW-1:0]     tx_cnt;
  logic [IW-1:0]     tx_idx;
  logic [DATA_W-1:0] tx_reg;
  logic              tx_line, tx_busy, tx_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_reg   <= '0;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (load_edge) begin
            tx_reg  <= bus.pb_in;
            tx_done <= 1'b0;
          end else if (start_edge) begin
            tx_state <= S_START;
            tx_cnt   <= '0;
            tx_line  <= 1'b0;
            tx_busy  <= 1'b1;
            tx_done  <= 1'b0;
          end
        end
        default: begin
          if (tx_cnt != LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            // Line value for the next bit is registered on the bit boundary.
            tx_cnt <= '0;
            case (tx_state)
              S_START: begin
                tx_state <= S_DATA;
                tx_idx   <= IDX_TOP;
                tx_line  <= tx_reg[DATA_W-1];
              end
              S_DATA: begin
                if (tx_idx != '0) begin
                  tx_idx  <= tx_idx - 1'b1;
                  tx_line <= tx_reg[tx_idx - 1'b1];
                end else if (PAR_EN) begin
                  tx_state <= S_PAR;
                  tx_line  <= ^tx_reg;
                end else begin
                  tx_state <= S_STOP;
                  tx_line  <= 1'b1;
                end
              end
              S_PAR: begin
                tx_state <= S_STOP;
                tx_line  <= 1'b1;
              end
              default: begin
                tx_state <= S_IDLE;
                tx_line  <= 1'b1;
                tx_busy  <= 1'b0;
                tx_done  <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

  logic [1:0]        rx_sync;
  logic              rx_bit, rx_mid, rx_last;
  logic [2:0]        rx_state;
  logic [CW-1:0]     rx_cnt;
  logic [IW-1:0]     rx_idx;
  logic [DATA_W-1:0] rx_shift, rx_word;
  logic              rx_par, rx_valid_q, frame_err_q;

  assign rx_bit  = rx_sync[1];
  assign rx_mid  = (rx_cnt == HALF);
  assign rx_last = (rx_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync     <= 2'b11;
      rx_state    <= S_IDLE;
      rx_cnt      <= '0;
      rx_idx      <= '0;
      rx_shift    <= '0;
      rx_word     <= '0;
      rx_par      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_sync     <= {rx_sync[0], bus.serial_in};
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          // The first low sample is count 0 of the start bit.
          if (!rx_bit) begin
            rx_idx <= IDX_TOP;
            if (LAST == '0) begin
              rx_state <= S_DATA;
              rx_cnt   <= '0;
            end else begin
              rx_state <= S_START;
              rx_cnt   <= CW'(1);
            end
          end
        end
        S_START: begin
          if (rx_mid && rx_bit) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
          end else if (rx_last) begin
            rx_state <= S_DATA;
            rx_cnt   <= '0;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: begin
          rx_cnt <= rx_last ? '0 : rx_cnt + 1'b1;
          if (rx_mid) begin
            case (rx_state)
              S_DATA: rx_shift <= {rx_shift[DATA_W-2:0], rx_bit};
              S_PAR:  rx_par   <= rx_bit;
              S_STOP: begin
                if (rx_bit && (!PAR_EN || (rx_par == ^rx_shift))) begin
                  rx_word    <= rx_shift;
                  rx_valid_q <= 1'b1;
                end else begin
                  frame_err_q <= 1'b1;
                end
              end
              default: ;
            endcase
          end
          if (rx_last) begin
            case (rx_state)
              S_DATA: begin
                if (rx_idx != '0) rx_idx <= rx_idx - 1'b1;
                else              rx_state <= PAR_EN ? S_PAR : S_STOP;
              end
              S_PAR:   rx_state <= S_STOP;
              default: rx_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 8'h3F;  4'h1: seg = 8'h06;  4'h2: seg = 8'h5B;  4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;  4'h5: seg = 8'h6D;  4'h6: seg = 8'h7D;  4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;  4'h9: seg = 8'h6F;  4'hA: seg = 8'h77;  4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;  4'hD: seg = 8'h5E;  4'hE: seg = 8'h79;  default: seg = 8'h71;
    endcase
  endfunction

  logic [8*NDIG-1:0] hex_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q <= {NDIG{8'h3F}};
    end else begin
      for (int i = 0; i < NDIG; i++) hex_q[8*i +: 8] <= seg(rx_word[4*i +: 4]);
    end
  end

  assign bus.serial_out = tx_line;
  assign bus.busy       = tx_busy;
  assign bus.done       = tx_done;
  assign bus.rx_valid   = rx_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.hex_out    = hex_q;
endmodule

// File: tb/tb_serial_link_hex.sv
// Loopback bench for serial_link_hex: a BIT_CYC=1 instance with line fault injection and a BIT_CYC=4 instance.
module tb_serial_link_hex;
  localparam int DW = 16;
`ifdef SERIAL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F1 = DW + 2 + P;
  localparam int F4 = (DW + 2 + P) * 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inj = 1'b0;
  always #5 clk = ~clk;

  serial_link_hex_if #(.DATA_W(DW)) bus1();
  serial_link_hex_if #(.DATA_W(DW)) bus4();
  assign bus1.serial_in = bus1.serial_out ^ inj;
  assign bus4.serial_in = bus4.serial_out;

  serial_link_hex #(.DATA_W(DW), .BIT_CYC(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  serial_link_hex #(.DATA_W(DW), .BIT_CYC(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                             8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  function automatic logic [31:0] hex_model(input logic [15:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = glyph[w[4*i +: 4]];
    return r;
  endfunction

  // Expected line level at cycle idx of a frame carrying w, bc cycles per bit.
  function automatic logic frame_bit(input logic [15:0] w, input int bc, input int idx);
    int pos;
    pos = idx / bc;
    if (pos == 0) return 1'b0;
    if (pos <= DW) return w[DW - pos];
    if (P == 1 && pos == DW + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press1(input logic ld, input logic st, input logic [15:0] w);
    bus1.pb_in = w;
    bus1.load_btn = ld;
    bus1.start_btn = st;
    tick();
    bus1.load_btn = 1'b0;
    bus1.start_btn = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] w);
    press1(1'b1, 1'b0, w);
    repeat (4) tick();
  endtask

  int   busy_len, n_valid, n_err;
  logic stream_ok;

  task automatic run_frame(input logic [15:0] w, input int inj_idx, input int btn_idx);
    int waitc;
    busy_len = 0; n_valid = 0; n_err = 0; stream_ok = 1'b1; waitc = 0;
    press1(1'b0, 1'b1, bus1.pb_in);
    while (!bus1.busy && waitc < 8) begin tick(); waitc++; end
    while (bus1.busy && busy_len < 4 * F1) begin
      if (bus1.serial_out !== frame_bit(w, 1, busy_len)) stream_ok = 1'b0;
      inj = (busy_len == inj_idx);
      if (busy_len == btn_idx) begin
        bus1.pb_in = ~w; bus1.load_btn = 1'b1; bus1.start_btn = 1'b1;
      end else begin
        bus1.load_btn = 1'b0; bus1.start_btn = 1'b0;
      end
      if (bus1.rx_valid) n_valid++;
      if (bus1.frame_err) n_err++;
      tick();
      busy_len++;
    end
    inj = 1'b0; bus1.load_btn = 1'b0; bus1.start_btn = 1'b0;
    repeat (8) begin
      if (bus1.rx_valid) n_valid++;
      if (bus1.frame_err) n_err++;
      tick();
    end
  endtask

  typedef struct {
    logic [15:0] word;
    logic [31:0] hex;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    int saw_busy;
    vecs[0] = '{16'hA5C3, 32'h776D394F};
    vecs[1] = '{16'h1234, 32'h065B4F66};
    vecs[2] = '{16'h89BE, 32'h7F6F7C79};
    vecs[3] = '{16'hFFFF, 32'h71717171};
    vecs[4] = '{16'h6D07, 32'h7D5E3F07};
    vecs[5] = '{16'h0000, 32'h3F3F3F3F};

    bus1.load_btn = 0; bus1.start_btn = 0; bus1.pb_in = '0;
    bus4.load_btn = 0; bus4.start_btn = 0; bus4.pb_in = '0;
    repeat (3) tick();
    check("rst_serial_out", bus1.serial_out, 1);
    check("rst_busy", bus1.busy, 0);
    check("rst_done", bus1.done, 0);
    check("rst_rx_valid", bus1.rx_valid, 0);
    check("rst_frame_err", bus1.frame_err, 0);
    check("rst_hex", bus1.hex_out, 32'h3F3F3F3F);
    check("rst_hex_bc4", bus4.hex_out, 32'h3F3F3F3F);
    reset = 1'b0;
    repeat (2) tick();

    // Start with nothing loaded sends zero.
    run_frame(16'h0000, -1, -1);
    check("unloaded_stream", stream_ok, 1);
    check("unloaded_len", busy_len, F1);
    check("unloaded_valid", n_valid, 1);
    check("unloaded_hex", bus1.hex_out, 32'h3F3F3F3F);

    foreach (vecs[i]) begin
      do_load(vecs[i].word);
      check("tbl_done_cleared", bus1.done, 0);
      run_frame(vecs[i].word, -1, -1);
      check("tbl_stream", stream_ok, 1);
      check("tbl_len", busy_len, F1);
      check("tbl_valid", n_valid, 1);
      check("tbl_err", n_err, 0);
      check("tbl_hex", bus1.hex_out, vecs[i].hex);
      check("tbl_done", bus1.done, 1);
    end

    // Load and start pressed mid-frame are ignored; a repeat start resends the same word.
    do_load(16'h5A3C);
    run_frame(16'h5A3C, -1, 5);
    check("midstart_len", busy_len, F1);
    check("midstart_valid", n_valid, 1);
    check("midstart_stream", stream_ok, 1);
    run_frame(16'h5A3C, -1, -1);
    check("midstart_txreg_kept", stream_ok, 1);
    check("midstart_hex", bus1.hex_out, hex_model(16'h5A3C));

    // Reset during frame cycle 7 aborts both directions.
    do_load(16'hA5C3);
    press1(1'b0, 1'b1, bus1.pb_in);
    saw_busy = 0;
    for (int i = 0; i < 8 && !bus1.busy; i++) tick();
    repeat (7) tick();
    reset = 1'b1;
    tick();
    check("midrst_serial_out", bus1.serial_out, 1);
    check("midrst_busy", bus1.busy, 0);
    check("midrst_done", bus1.done, 0);
    reset = 1'b0;
    n_valid = 0;
    repeat (25) begin
      if (bus1.rx_valid) n_valid++;
      tick();
    end
    check("midrst_no_valid", n_valid, 0);
    check("midrst_hex", bus1.hex_out, 32'h3F3F3F3F);

    // Stop bit forced low on the line.
    do_load(16'hA5C3);
    run_frame(16'hA5C3, F1 - 1, -1);
    check("badstop_err", n_err, 1);
    check("badstop_valid", n_valid, 0);
    check("badstop_hex_kept", bus1.hex_out, 32'h3F3F3F3F);
`ifdef SERIAL_PARITY_EN
    run_frame(16'hA5C3, DW + 1, -1);
    check("badpar_stream", stream_ok, 1);
    check("badpar_err", n_err, 1);
    check("badpar_valid", n_valid, 0);
    check("badpar_hex_kept", bus1.hex_out, 32'h3F3F3F3F);
`endif

    // Simultaneous load and start in idle: load wins, no frame.
    press1(1'b1, 1'b1, 16'h1234);
    saw_busy = 0;
    repeat (10) begin
      if (bus1.busy) saw_busy = 1;
      tick();
    end
    check("simul_no_frame", saw_busy, 0);
    check("simul_done", bus1.done, 0);
    run_frame(16'h1234, -1, -1);
    check("simul_loaded_stream", stream_ok, 1);
    check("simul_loaded_hex", bus1.hex_out, 32'h065B4F66);

    for (int r = 0; r < 12; r++) begin
      w = 16'($urandom);
      do_load(w);
      run_frame(w, -1, -1);
      check("rnd_stream", stream_ok, 1);
      check("rnd_len", busy_len, F1);
      check("rnd_valid", n_valid, 1);
      check("rnd_hex", bus1.hex_out, hex_model(w));
    end

    // Four clock cycles per bit.
    bus4.pb_in = 16'h00FF;
    bus4.load_btn = 1'b1; tick(); bus4.load_btn = 1'b0;
    repeat (4) tick();
    bus4.start_btn = 1'b1; tick(); bus4.start_btn = 1'b0;
    for (int i = 0; i < 8 && !bus4.busy; i++) tick();
    busy_len = 0; n_valid = 0; stream_ok = 1'b1;
    while (bus4.busy && busy_len < 4 * F4) begin
      if (bus4.serial_out !== frame_bit(16'h00FF, 4, busy_len)) stream_ok = 1'b0;
      if (bus4.rx_valid) n_valid++;
      tick();
      busy_len++;
    end
    repeat (16) begin
      if (bus4.rx_valid) n_valid++;
      tick();
    end
    check("bc4_len", busy_len, F4);
    check("bc4_stream", stream_ok, 1);
    check("bc4_valid", n_valid, 1);
    check("bc4_hex", bus4.hex_out, 32'h3F3F7171);
    check("bc4_done", bus4.done, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
